exception_unit: RTL and testbench
=================================

// Module: exception_unit
// PURPOSE
//  Upstream feeder of the CP0 block. Collects the memory-stage exception report, ERET and six
//  external interrupt lines. Selects one event per cycle by priority and drives CP0's
//  isException/exceptionCause/exceptionPC. Holds a one-cycle flush window after each event.
//  Also returns synchronised interrupt-pending bits for Cause.IP.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop depth of the hwInt synchroniser (>=2)
//  NUM_HWINT    6   external interrupt lines; matches the Cause.IP/SR.IM width
//  COUNT_WIDTH  16  width of the saturating taken-event counter
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low; all state cleared while 0
//  hwInt          in   6   asynchronous external interrupt requests, level, active-high
//  statusIM       in   6   SR.IM from CP0
//  statusIE       in   1   SR.IE from CP0
//  statusEXL      in   1   SR.EXL from CP0
//  memValid       in   1   M stage holds a real (non-bubble) instruction
//  memStall       in   1   M stage is not committing this cycle
//  memPC          in   32  PC of the M-stage instruction
//  memBD          in   1   M-stage instruction is in a branch delay slot
//  memExc         in   1   M-stage instruction raised a synchronous exception
//  memExcCode     in   5   cause code of that exception
//  memERET        in   1   M-stage instruction is ERET
//  isException    out  1   event to CP0 this cycle
//  exceptionCause out  5   cause code to CP0 (`causeERET for ERET, 0 for interrupt)
//  exceptionPC    out  32  EPC value to CP0
//  exceptionBD    out  1   branch-delay flag for Cause.BD
//  flush          out  1   kill F/D/E/M instructions
//  ipPending      out  6   synchronised hwInt, for Cause.IP
//  eventCount     out  16  saturating count of non-ERET events taken
// BEHAVIOUR
//  Reset values: synchroniser=0, state=IDLE, eventCount=0; all outputs 0 during reset.
//  Synchroniser: SYNC_STAGES flops per line; ipPending = last stage; latency SYNC_STAGES cycles.
//  intReq  = |(ipPending & statusIM) & statusIE & ~statusEXL.
//  commit  = memValid & ~memStall & (state==IDLE).
//  Priority when commit=1, highest first:
//   1. intReq -> cause 0; pre-empts memExc and memERET of the same instruction.
//   2. memExc -> cause memExcCode.
//   3. memERET -> cause `causeERET.
//  Event output is combinational in the same cycle, so CP0 latches it at the next edge.
//  exceptionPC = memBD ? memPC-32'd4 : memPC (modulo 2^32). exceptionBD = memBD.
//  For ERET, exceptionPC and exceptionBD are don't-care; drive memPC and 0.
//  If commit=0 then isException=0, and cause/PC are held at 0.
//  flush = isException (same cycle); the instruction in M is not retired.
//  FSM:
//   IDLE  -> FLUSH  on isException.
//   FLUSH -> IDLE   unconditionally after 1 cycle.
//   FLUSH blocks all events. This covers the cycle in which CP0's EXL/EPC update is not yet
//   visible. It also blocks a fresh interrupt on the first fetched handler/return instruction.
//  eventCount: +1 per non-ERET event; saturates at all-ones, no wrap.
//  Reset asserted mid-FLUSH: state returns to IDLE and the pending flush is dropped.
//  memExc and memERET both set (illegal): memExc wins.
//  memStall=1 with an active intReq: the interrupt waits and is taken on the first commit cycle.
//  A masked or EXL-blocked interrupt stays visible on ipPending; it is never latched as taken.
// TESTING
//  T1 hwInt[2]=1, IM=6'h3F, IE=1, EXL=0, memValid=1, memPC=0x3000
//     -> ipPending[2] rises after 2 clk; isException=1, cause=0, exceptionPC=0x3000, flush=1.
//     Next cycle FLUSH with isException=0; eventCount=1.
//  T2 memExc=1, code=12, memBD=1, memPC=0x3010
//     -> cause=12, exceptionPC=0x300C, exceptionBD=1.
//  T3 memERET=1 and hwInt[0] asserted in the same cycle, IM[0]=1
//     -> cause=0 (interrupt wins), exceptionPC=ERET's PC.
//  T4 interrupt pending with memStall=1 for 3 cycles
//     -> no event for those 3 cycles; event in the first cycle memStall=0.
//     Repeat with EXL=1: no event ever.
//  T5 back-to-back memExc in 2 consecutive cycles -> only the first is taken.
//     Second is blocked by FLUSH; third cycle is taken again.
//  T6 reset=0 during FLUSH -> flush=0, eventCount=0 immediately, state IDLE after release.
//     Also force 65535 events -> eventCount stays 0xFFFF.

Source files
------------

// File: rtl/exception_unit.sv
// exception_unit: prioritises interrupt/exception/ERET events for CP0 and holds a one-cycle flush window.
// Also synchronises the external interrupt lines and counts the events taken.
module exception_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_HWINT = 6,
    parameter int COUNT_WIDTH = 16,
    parameter logic [4:0] CAUSE_ERET = 5'd31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_HWINT-1:0]   hwInt,
    input  logic [NUM_HWINT-1:0]   statusIM,
    input  logic                   statusIE,
    input  logic                   statusEXL,
    input  logic                   memValid,
    input  logic                   memStall,
    input  logic [31:0]            memPC,
    input  logic                   memBD,
    input  logic                   memExc,
    input  logic [4:0]             memExcCode,
    input  logic                   memERET,
    output logic                   isException,
    output logic [4:0]             exceptionCause,
    output logic [31:0]            exceptionPC,
    output logic                   exceptionBD,
    output logic                   flush,
    output logic [NUM_HWINT-1:0]   ipPending,
    output logic [COUNT_WIDTH-1:0] eventCount
);
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;
    state_t state, nextState;
    logic [SYNC_STAGES-1:0][NUM_HWINT-1:0] syncQ;
    logic intReq, commit, takeEret;

    always_ff @(posedge clk or negedge reset)
        if (!reset) syncQ <= '0;
        else        syncQ <= {syncQ[SYNC_STAGES-2:0], hwInt};

    assign ipPending = syncQ[SYNC_STAGES-1];
    assign intReq = |(ipPending & statusIM) & statusIE & ~statusEXL;
    // Gated by reset so the combinational event path stays quiet while reset is held.
    assign commit = reset & memValid & ~memStall & (state == IDLE);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nextState;

    always_comb nextState = (state == IDLE && isException) ? FLUSH : IDLE;

    always_comb begin
        isException    = commit & (intReq | memExc | memERET);
        takeEret       = isException & ~intReq & ~memExc;
        exceptionCause = !isException ? 5'd0 : intReq ? 5'd0 : memExc ? memExcCode : CAUSE_ERET;
        exceptionBD    = isException & ~takeEret & memBD;
        exceptionPC    = !isException ? 32'd0 : exceptionBD ? memPC - 32'd4 : memPC;
        flush          = isException;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) eventCount <= '0;
        else if (isException && !takeEret && !(&eventCount)) eventCount <= eventCount + 1'b1;
endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: directed tests of event priority, flush window, synchroniser and counter.
// A narrow counter instance keeps the saturation test short.
module tb_exception_unit;
    localparam int CW = 8;
    localparam logic [4:0] ERET_CODE = 5'd31;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] hwInt = '0, statusIM = '0;
    logic statusIE = 1'b0, statusEXL = 1'b0, memValid = 1'b0, memStall = 1'b0;
    logic [31:0] memPC = '0;
    logic memBD = 1'b0, memExc = 1'b0, memERET = 1'b0;
    logic [4:0] memExcCode = '0;
    logic isException, exceptionBD, flush;
    logic [4:0] exceptionCause;
    logic [31:0] exceptionPC;
    logic [5:0] ipPending;
    logic [CW-1:0] eventCount;
    int vectors = 0, miscompares = 0;

    exception_unit #(.SYNC_STAGES(2), .NUM_HWINT(6), .COUNT_WIDTH(CW), .CAUSE_ERET(ERET_CODE)) dut (
        .clk(clk), .reset(reset), .hwInt(hwInt), .statusIM(statusIM), .statusIE(statusIE),
        .statusEXL(statusEXL), .memValid(memValid), .memStall(memStall), .memPC(memPC),
        .memBD(memBD), .memExc(memExc), .memExcCode(memExcCode), .memERET(memERET),
        .isException(isException), .exceptionCause(exceptionCause), .exceptionPC(exceptionPC),
        .exceptionBD(exceptionBD), .flush(flush), .ipPending(ipPending), .eventCount(eventCount)
    );

    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        hwInt = 6'h3F; statusIM = 6'h3F; statusIE = 1'b1; memValid = 1'b1; memExc = 1'b1; memExcCode = 5'd7; memPC = 32'h1234;
        waitCycles(2); #1;
        vectors++; if (isException !== 1'b0) begin miscompares++; $display("FAIL rst_exc got=%0b exp=0", isException); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush got=%0b exp=0", flush); end
        vectors++; if (exceptionPC !== 32'd0) begin miscompares++; $display("FAIL rst_pc got=%h exp=0", exceptionPC); end
        vectors++; if (ipPending !== 6'h00) begin miscompares++; $display("FAIL rst_ip got=%h exp=00", ipPending); end
        vectors++; if (eventCount !== '0) begin miscompares++; $display("FAIL rst_cnt got=%0d exp=0", eventCount); end
        @(negedge clk);
        hwInt = '0; statusIM = '0; statusIE = 1'b0; memValid = 1'b0; memExc = 1'b0; memExcCode = '0; memPC = '0;
        reset = 1'b1;
        waitCycles(3);
    endtask

    task automatic test_interrupt;
        @(negedge clk);
        hwInt = 6'h04; statusIM = 6'h3F; statusIE = 1'b1; memValid = 1'b1; memPC = 32'h3000;
        #1;
        vectors++; if (ipPending !== 6'h00) begin miscompares++; $display("FAIL t1_ip0 got=%h exp=00", ipPending); end
        @(negedge clk); #1;
        vectors++; if (isException !== 1'b0) begin miscompares++; $display("FAIL t1_early got=%0b exp=0", isException); end
        @(negedge clk); #1;
        vectors++; if (ipPending !== 6'h04) begin miscompares++; $display("FAIL t1_ip got=%h exp=04", ipPending); end
        vectors++; if (isException !== 1'b1) begin miscompares++; $display("FAIL t1_exc got=%0b exp=1", isException); end
        vectors++; if (exceptionCause !== 5'd0) begin miscompares++; $display("FAIL t1_cause got=%0d exp=0", exceptionCause); end
        vectors++; if (exceptionPC !== 32'h3000) begin miscompares++; $display("FAIL t1_pc got=%h exp=3000", exceptionPC); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL t1_flush got=%0b exp=1", flush); end
        @(negedge clk); #1;
        vectors++; if (isException !== 1'b0) begin miscompares++; $display("FAIL t1_flushstate got=%0b exp=0", isException); end
        vectors++; if (eventCount !== 8'd1) begin miscompares++; $display("FAIL t1_cnt got=%0d exp=1", eventCount); end
        statusIE = 1'b0; hwInt = '0; memValid = 1'b0;
        waitCycles(3);
    endtask

    task automatic test_exception;
        @(negedge clk);
        memValid = 1'b1; memExc = 1'b1; memExcCode = 5'd12; memBD = 1'b1; memPC = 32'h3010;
        #1;
        vectors++; if (isException !== 1'b1) begin miscompares++; $display("FAIL t2_exc got=%0b exp=1", isException); end
        vectors++; if (exceptionCause !== 5'd12) begin miscompares++; $display("FAIL t2_cause got=%0d exp=12", exceptionCause); end
        vectors++; if (exceptionPC !== 32'h300C) begin miscompares++; $display("FAIL t2_pc got=%h exp=300c", exceptionPC); end
        vectors++; if (exceptionBD !== 1'b1) begin miscompares++; $display("FAIL t2_bd got=%0b exp=1", exceptionBD); end
        @(negedge clk);
        memValid = 1'b0; memExc = 1'b0; memBD = 1'b0;
        #1;
        vectors++; if (eventCount !== 8'd2) begin miscompares++; $display("FAIL t2_cnt got=%0d exp=2", eventCount); end
        @(negedge clk);
    endtask

    task automatic test_priority;
        memValid = 1'b1; memExc = 1'b1; memERET = 1'b1; memExcCode = 5'd8; memPC = 32'h3020;
        #1;
        vectors++; if (exceptionCause !== 5'd8) begin miscompares++; $display("FAIL pri_excwins got=%0d exp=8", exceptionCause); end
        @(negedge clk);
        memValid = 1'b0; memExc = 1'b0; memERET = 1'b0;
        @(negedge clk);
        memValid = 1'b1; memERET = 1'b1; memBD = 1'b1; memPC = 32'h3030;
        #1;
        vectors++; if (exceptionCause !== ERET_CODE) begin miscompares++; $display("FAIL eret_cause got=%0d exp=%0d", exceptionCause, ERET_CODE); end
        vectors++; if (exceptionPC !== 32'h3030) begin miscompares++; $display("FAIL eret_pc got=%h exp=3030", exceptionPC); end
        vectors++; if (exceptionBD !== 1'b0) begin miscompares++; $display("FAIL eret_bd got=%0b exp=0", exceptionBD); end
        @(negedge clk);
        memValid = 1'b0; memERET = 1'b0; memBD = 1'b0;
        #1;
        vectors++; if (eventCount !== 8'd3) begin miscompares++; $display("FAIL eret_cnt got=%0d exp=3", eventCount); end
        @(negedge clk);
        memValid = 1'b1; memExc = 1'b1; memExcCode = 5'd10; memBD = 1'b1; memPC = 32'h0;
        #1;
        vectors++; if (exceptionPC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL bd_wrap got=%h exp=fffffffc", exceptionPC); end
        @(negedge clk);
        memValid = 1'b0; memExc = 1'b0; memBD = 1'b0;
        #1;
        vectors++; if (eventCount !== 8'd4) begin miscompares++; $display("FAIL wrap_cnt got=%0d exp=4", eventCount); end
        @(negedge clk);
    endtask

    task automatic test_int_over_eret;
        hwInt = 6'h01; statusIM = 6'h01; statusIE = 1'b1;
        waitCycles(2);
        memValid = 1'b1; memERET = 1'b1; memPC = 32'h4000;
        #1;
        vectors++; if (isException !== 1'b1) begin miscompares++; $display("FAIL t3_exc got=%0b exp=1", isException); end
        vectors++; if (exceptionCause !== 5'd0) begin miscompares++; $display("FAIL t3_cause got=%0d exp=0", exceptionCause); end
        vectors++; if (exceptionPC !== 32'h4000) begin miscompares++; $display("FAIL t3_pc got=%h exp=4000", exceptionPC); end
        @(negedge clk);
        memValid = 1'b0; memERET = 1'b0; statusIE = 1'b0; hwInt = '0;
        #1;
        vectors++; if (eventCount !== 8'd5) begin miscompares++; $display("FAIL t3_cnt got=%0d exp=5", eventCount); end
        waitCycles(3);
    endtask

    task automatic test_stall_and_mask;
        hwInt = 6'h02; statusIM = 6'h3F; statusIE = 1'b1; memValid = 1'b1; memStall = 1'b1; memPC = 32'h5000;
        waitCycles(2);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (isException !== 1'b0) begin miscompares++; $display("FAIL t4_stall%0d got=%0b exp=0", i, isException); end
            @(negedge clk);
        end
        memStall = 1'b0;
        #1;
        vectors++; if (isException !== 1'b1) begin miscompares++; $display("FAIL t4_release got=%0b exp=1", isException); end
        vectors++; if (exceptionPC !== 32'h5000) begin miscompares++; $display("FAIL t4_pc got=%h exp=5000", exceptionPC); end
        @(negedge clk);
        memValid = 1'b0;
        #1;
        vectors++; if (eventCount !== 8'd6) begin miscompares++; $display("FAIL t4_cnt got=%0d exp=6", eventCount); end
        @(negedge clk);
        statusEXL = 1'b1; memValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (isException !== 1'b0) begin miscompares++; $display("FAIL t4_exl%0d got=%0b exp=0", i, isException); end
            vectors++; if (ipPending !== 6'h02) begin miscompares++; $display("FAIL t4_ipvis%0d got=%h exp=02", i, ipPending); end
            @(negedge clk);
        end
        statusEXL = 1'b0; statusIM = 6'h3D;
        #1;
        vectors++; if (isException !== 1'b0) begin miscompares++; $display("FAIL t4_masked got=%0b exp=0", isException); end
        @(negedge clk);
        memValid = 1'b0; statusIE = 1'b0; hwInt = '0; statusIM = 6'h3F;
        waitCycles(3);
    endtask

    task automatic test_back_to_back;
        memValid = 1'b1; memExc = 1'b1; memExcCode = 5'd4; memPC = 32'h6000;
        #1;
        vectors++; if (exceptionCause !== 5'd4 || isException !== 1'b1) begin miscompares++; $display("FAIL t5_first got=%0b/%0d exp=1/4", isException, exceptionCause); end
        @(negedge clk);
        memExcCode = 5'd5; memPC = 32'h6004;
        #1;
        vectors++; if (isException !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL t5_blocked got=%0b/%0b exp=0/0", isException, flush); end
        @(negedge clk);
        memExcCode = 5'd6; memPC = 32'h6008;
        #1;
        vectors++; if (exceptionCause !== 5'd6 || isException !== 1'b1) begin miscompares++; $display("FAIL t5_third got=%0b/%0d exp=1/6", isException, exceptionCause); end
        vectors++; if (exceptionPC !== 32'h6008) begin miscompares++; $display("FAIL t5_pc got=%h exp=6008", exceptionPC); end
        @(negedge clk);
        memValid = 1'b0; memExc = 1'b0;
        #1;
        vectors++; if (eventCount !== 8'd8) begin miscompares++; $display("FAIL t5_cnt got=%0d exp=8", eventCount); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_flush;
        memValid = 1'b1; memExc = 1'b1; memExcCode = 5'd3; memPC = 32'h7000;
        #1;
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL t6_flush got=%0b exp=1", flush); end
        @(negedge clk); #1;
        vectors++; if (eventCount !== 8'd9) begin miscompares++; $display("FAIL t6_cnt9 got=%0d exp=9", eventCount); end
        reset = 1'b0;
        #1;
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL t6_rstflush got=%0b exp=0", flush); end
        vectors++; if (eventCount !== '0) begin miscompares++; $display("FAIL t6_rstcnt got=%0d exp=0", eventCount); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (isException !== 1'b1 || exceptionCause !== 5'd3) begin miscompares++; $display("FAIL t6_idle got=%0b/%0d exp=1/3", isException, exceptionCause); end
        waitCycles(600);
        memValid = 1'b0; memExc = 1'b0;
        @(negedge clk); #1;
        vectors++; if (eventCount !== {CW{1'b1}}) begin miscompares++; $display("FAIL t6_sat got=%0d exp=%0d", eventCount, {CW{1'b1}}); end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception();
        test_priority();
        test_int_over_eret();
        test_stall_and_mask();
        test_back_to_back();
        test_reset_in_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
